// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-rate enable, scan counters, frame-start pulse,
// and sync/colour output stage delayed to line up with the object mux colour.
module vga_sync_gen #(
  parameter int CLK_DIV    = 2,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [7:0]  RGBin,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        pixelEn,
  output logic        startOfFrame,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [10:0] X_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] Y_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] X_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] Y_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic active;
    logic hs_n;
    logic vs_n;
  } timing_t;

  localparam timing_t TIMING_IDLE = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_en_q, pix_en_d;
  logic [10:0]      x_q, x_d, y_q, y_d;
  logic             sof_q, sof_d;
  timing_t          raw;
  timing_t          pipe_q [PIPE_DELAY];
  timing_t          pipe_d [PIPE_DELAY];
  logic             hs_q, hs_d, vs_q, vs_d;
  logic [3:0]       red_q, red_d, green_q, green_d, blue_q, blue_d;

  always_comb begin
    // pixel enable is registered from the next divider value so it reads 0 in reset
    div_d    = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    pix_en_d = (div_d == DIV_LAST);

    x_d   = x_q;
    y_d   = y_q;
    sof_d = 1'b0;
    if (pix_en_q) begin
      if (x_q == X_LAST) begin
        x_d   = '0;
        y_d   = (y_q == Y_LAST) ? '0 : y_q + 11'd1;
        sof_d = (y_q == Y_LAST);
      end else begin
        x_d = x_q + 11'd1;
      end
    end

    raw.active = (x_q < X_ACT) && (y_q < Y_ACT);
    raw.hs_n   = !((x_q >= HS_START) && (x_q < HS_END));
    raw.vs_n   = !((y_q >= VS_START) && (y_q < VS_END));

    pipe_d = pipe_q;
    if (pix_en_q) begin
      pipe_d[0] = raw;
      for (int i = 1; i < PIPE_DELAY; i++) pipe_d[i] = pipe_q[i-1];
    end

    hs_d    = hs_q;
    vs_d    = vs_q;
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;
    if (pix_en_q) begin
      hs_d = pipe_q[PIPE_DELAY-1].hs_n;
      vs_d = pipe_q[PIPE_DELAY-1].vs_n;
      // 3/3/2-bit channels widened to 4 bits by replicating their top bits
      if (pipe_q[PIPE_DELAY-1].active) begin
        red_d   = {RGBin[7:5], RGBin[7]};
        green_d = {RGBin[4:2], RGBin[4]};
        blue_d  = {RGBin[1:0], RGBin[1:0]};
      end else begin
        red_d   = 4'h0;
        green_d = 4'h0;
        blue_d  = 4'h0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      div_q    <= '0;
      pix_en_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      sof_q    <= 1'b0;
      for (int i = 0; i < PIPE_DELAY; i++) pipe_q[i] <= TIMING_IDLE;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      red_q    <= 4'h0;
      green_q  <= 4'h0;
      blue_q   <= 4'h0;
    end else begin
      div_q    <= div_d;
      pix_en_q <= pix_en_d;
      x_q      <= x_d;
      y_q      <= y_d;
      sof_q    <= sof_d;
      pipe_q   <= pipe_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      red_q    <= red_d;
      green_q  <= green_d;
      blue_q   <= blue_d;
    end
  end

  assign pixelX       = x_q;
  assign pixelY       = y_q;
  assign pixelEn      = pix_en_q;
  assign startOfFrame = sof_q;
  assign hsync        = hs_q;
  assign vsync        = vs_q;
  assign red          = red_q;
  assign green        = green_q;
  assign blue         = blue_q;

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Display-side end of the pixel-object interface: generates the raster scan coordinates (pixelX, pixelY) that every drawing object consumes.
- Takes back the final 8-bit RRRGGGBB colour from the object mux and drives VGA hsync/vsync/RGB with correct pipeline alignment.
- Also supplies the pixel-rate enable and a frame-start pulse for game logic.
- Sits at the top of the video path, between the object/mux layer and the board VGA DAC.

Parameters:
- CLK_DIV, 2, clk cycles per pixel (50 MHz clk -> 25 MHz pixel); must be >=1
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, pixels
- H_SYNC, 96, hsync pulse width, pixels
- H_BP, 48, horizontal back porch, pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, lines
- V_SYNC, 2, vsync pulse width, lines
- V_BP, 33, vertical back porch, lines
- PIPE_DELAY, 1, pixel ticks from pixelX/pixelY presentation to valid RGBin; must be >=1

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- RGBin  in  8  final pixel colour from object mux, RRRGGGBB
- pixelX  out  11  raw horizontal counter, 0..H_TOTAL-1
- pixelY  out  11  raw vertical counter, 0..V_TOTAL-1
- pixelEn  out  1  one-clk pulse per pixel tick
- startOfFrame  out  1  one-clk pulse when counters wrap to (0,0)
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- red  out  4  VGA red
- green  out  4  VGA green
- blue  out  4  VGA blue

Behaviour:
- Totals: H_TOTAL = sum of the four H params (800); V_TOTAL = sum of the four V params (525).
- Reset is asynchronous and applies immediately:
  - divider = 0, pixelX = pixelY = 0, pixelEn = 0, startOfFrame = 0
  - hsync = vsync = 1, red = green = blue = 0
  - all delay-line stages cleared to blank/inactive-sync
- Divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - pixelEn = 1 for exactly one clk when divider == CLK_DIV-1.
  - CLK_DIV = 1 gives pixelEn constantly high after reset.
- Counters advance only on pixelEn:
  - pixelX increments; at H_TOTAL-1 it wraps to 0 and pixelY increments.
  - pixelY wraps from V_TOTAL-1 to 0.
  - pixelX and pixelY are registered; pixelX hold steady between ticks.
  - Counters keep running through blanking; values >= H_ACTIVE/V_ACTIVE are legal outputs.
- startOfFrame: asserted in the clk where the counters transition from (H_TOTAL-1, V_TOTAL-1) to (0,0). Not asserted at reset release.
- Raw timing, from the current counter values:
  - activeRaw = (pixelX < H_ACTIVE) && (pixelY < V_ACTIVE)
  - hsRaw low when H_ACTIVE+H_FP <= pixelX < H_ACTIVE+H_FP+H_SYNC (656..751)
  - vsRaw low when V_ACTIVE+V_FP <= pixelY < V_ACTIVE+V_FP+V_SYNC (490..491)
- Alignment: activeRaw, hsRaw and vsRaw pass through a PIPE_DELAY-stage shift register clocked on pixelEn, so they line up with RGBin.
- Output stage, on pixelEn:
  - hsync/vsync take the delayed values.
  - If delayed active = 1: red = {R[2:0], R[2]}, green = {G[2:0], G[2]}, blue = {B[1:0], B[1:0]}.
  - Otherwise red = green = blue = 0.
  - Net latency: pixelX/pixelY to pins = PIPE_DELAY+1 pixel ticks, identical for colour and sync.
- RGBin is sampled only on pixelEn; changes between ticks are ignored.
- Transparent encoding 8'hFF has no special meaning here; the mux resolves it. 8'hFF displays as white.
- No state machine beyond the counters; no illegal counter states are reachable. Parameter overrides must keep the totals within 11 bits.

Test Plan:
- Reset/divider: hold resetN=0 -> hsync=vsync=1, RGB=0, pixelX=pixelY=0. Release -> pixelEn pattern 0,1,0,1; pixelX reaches 1 on the 2nd clk edge after release.
- Line timing: free-run 2 lines -> hsync low exactly 96 ticks (192 clk), period 800 ticks; hsync falls PIPE_DELAY+1 ticks after pixelX becomes 656.
- Frame timing: run 2 frames -> vsync low exactly 1600 ticks, period 420000 ticks; startOfFrame pulses exactly once per 840000 clk, each time with pixelX=pixelY=0.
- Alignment: bench object registers RGBin=8'hE0 when pixelX==0 or pixelX==639, else 8'h00 (1-tick latency) -> red=4'hF on exactly the first and last active pixel of each line, red=0 elsewhere.
- Blanking: RGBin fixed at 8'hFF -> red=green=blue=4'hF for exactly 307200 ticks per frame; all zero during every hsync/vsync/porch tick.
- Mid-frame reset: assert resetN=0 while pixelY=300 -> outputs at reset values in the same clk without waiting for an edge. After release, scan restarts at (0,0); first vsync low occurs at line 490.
